// File: rtl/tbcm_arbiter_pkg.sv
// ============================================================================
// Module      : tbcm_arbiter_pkg
// Description : Shared types for the tbcm stream arbiter family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tbcm_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } tbcm_arbiter_state_e;

endpackage

`default_nettype wire

// File: rtl/tbcm_rr_priority.sv
// ============================================================================
// Module      : tbcm_rr_priority
// Description : Combinational round-robin pick: first set request at or after
//               a one-hot pointer, wrapping from the top entry to entry 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tbcm_rr_priority #(
    parameter  int REQUESTS    = 2,
    localparam int INDEX_WIDTH = (REQUESTS > 1) ? $clog2(REQUESTS) : 1
) (
    input  logic [REQUESTS-1:0]    request,
    input  logic [REQUESTS-1:0]    pointer,
    output logic [REQUESTS-1:0]    winner,
    output logic [INDEX_WIDTH-1:0] winner_index
);

    int   w_ptr_idx;
    int   w_slot;
    logic w_found;

    always_comb begin
        w_ptr_idx    = 0;
        w_slot       = 0;
        w_found      = 1'b0;
        winner       = '0;
        winner_index = '0;
        for (int i = 0; i < REQUESTS; i++) begin
            if (pointer[i]) begin
                w_ptr_idx = i;
            end
        end
        // Walk the ring starting at the pointer; the first hit wins.
        for (int k = 0; k < REQUESTS; k++) begin
            w_slot = w_ptr_idx + k;
            if (w_slot >= REQUESTS) begin
                w_slot = w_slot - REQUESTS;
            end
            if (!w_found && request[w_slot]) begin
                w_found         = 1'b1;
                winner[w_slot]  = 1'b1;
                winner_index    = w_slot[INDEX_WIDTH-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tbcm_stream_arbiter.sv
// ============================================================================
// Module      : tbcm_stream_arbiter
// Description : Round-robin stream arbiter with valid/ready handshake and
//               packet lock; drives the select input of tbcm_mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tbcm_stream_arbiter
    import tbcm_arbiter_pkg::*;
#(
    parameter  int REQUESTS    = 2,
    localparam int INDEX_WIDTH = (REQUESTS > 1) ? $clog2(REQUESTS) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [REQUESTS-1:0]    i_request,
    input  logic [REQUESTS-1:0]    i_last,
    output logic [REQUESTS-1:0]    o_ready,
    output logic [REQUESTS-1:0]    o_grant,
    output logic [INDEX_WIDTH-1:0] o_grant_index,
    output logic                   o_valid,
    input  logic                   i_ready
);

    tbcm_arbiter_state_e    r_state;
    tbcm_arbiter_state_e    w_state_next;
    logic [REQUESTS-1:0]    r_pointer;
    logic [REQUESTS-1:0]    w_pointer_next;
    logic [REQUESTS-1:0]    r_held;
    logic [REQUESTS-1:0]    w_held_next;
    logic [INDEX_WIDTH-1:0] r_held_index;
    logic [INDEX_WIDTH-1:0] w_held_index_next;

    logic [REQUESTS-1:0]    w_winner;
    logic [INDEX_WIDTH-1:0] w_winner_index;
    logic [REQUESTS-1:0]    w_advance;
    logic                   w_handshake;
    logic                   w_last;

    tbcm_rr_priority #(
        .REQUESTS     (REQUESTS)
    ) u_priority (
        .request      (i_request),
        .pointer      (r_pointer),
        .winner       (w_winner),
        .winner_index (w_winner_index)
    );

    // Next pointer is the current grant rotated left by one.
    generate
        if (REQUESTS == 1) begin : g_single
            assign w_advance = r_pointer;
        end else begin : g_rotate
            assign w_advance = {o_grant[REQUESTS-2:0], o_grant[REQUESTS-1]};
        end
    endgenerate

    always_comb begin
        o_grant       = '0;
        o_grant_index = '0;
        o_valid       = 1'b0;
        if (i_rst_n) begin
            if (r_state == IDLE) begin
                o_grant       = w_winner;
                o_grant_index = w_winner_index;
                o_valid       = |i_request;
            end else begin
                o_grant       = r_held;
                o_grant_index = r_held_index;
                o_valid       = |(i_request & r_held);
            end
        end
    end

    assign o_ready     = o_grant & {REQUESTS{i_ready}};
    assign w_handshake = o_valid & i_ready;
    assign w_last      = |(i_last & o_grant);

    always_comb begin
        w_state_next      = r_state;
        w_pointer_next    = r_pointer;
        w_held_next       = r_held;
        w_held_index_next = r_held_index;
        case (r_state)
            IDLE: begin
                if (o_valid) begin
                    // Lock on a stall as well, so the grant cannot move under a waiting beat.
                    if (!i_ready || !w_last) begin
                        w_state_next      = BUSY;
                        w_held_next       = w_winner;
                        w_held_index_next = w_winner_index;
                    end else begin
                        w_pointer_next = w_advance;
                    end
                end
            end
            BUSY: begin
                if (w_handshake && w_last) begin
                    w_state_next      = IDLE;
                    w_pointer_next    = w_advance;
                    w_held_next       = '0;
                    w_held_index_next = '0;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_pointer    <= {{(REQUESTS-1){1'b0}}, 1'b1};
            r_held       <= '0;
            r_held_index <= '0;
        end else begin
            r_state      <= w_state_next;
            r_pointer    <= w_pointer_next;
            r_held       <= w_held_next;
            r_held_index <= w_held_index_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tbcm_stream_arbiter.sv
// ============================================================================
// Module      : tb_tbcm_stream_arbiter
// Description : Self-checking bench for tbcm_stream_arbiter (4-way and 1-way).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tbcm_stream_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req4, last4;
    logic       rdy4;
    logic [3:0] o_ready4, o_grant4;
    logic [1:0] o_index4;
    logic       o_valid4;
    logic       req1, last1, rdy1;
    logic       o_ready1, o_grant1, o_index1, o_valid1;

    int checks = 0;
    int errors = 0;

    tbcm_stream_arbiter #(.REQUESTS(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_request(req4), .i_last(last4),
        .o_ready(o_ready4), .o_grant(o_grant4), .o_grant_index(o_index4),
        .o_valid(o_valid4), .i_ready(rdy4)
    );

    tbcm_stream_arbiter #(.REQUESTS(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_request(req1), .i_last(last1),
        .o_ready(o_ready1), .o_grant(o_grant1), .o_grant_index(o_index1),
        .o_valid(o_valid1), .i_ready(rdy1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a lock flag, locked channel and pointer as plain integers.
    function automatic void model_out(input int n, input bit lk, input int lch, input int ptr,
                                      input logic [3:0] req, input bit rstn,
                                      output logic v, output logic [3:0] g, output int idx);
        int c;
        v = 1'b0; g = '0; idx = 0;
        if (!rstn) return;
        if (lk) begin
            g[lch] = 1'b1; v = req[lch]; idx = lch;
        end else begin
            for (int k = 0; k < n; k++) begin
                c = (ptr + k) % n;
                if (req[c]) begin
                    g[c] = 1'b1; v = 1'b1; idx = c;
                    break;
                end
            end
        end
    endfunction

    function automatic void model_next(input int n, input logic [3:0] req, input logic [3:0] lst,
                                       input bit rdy, input bit rstn,
                                       inout bit lk, inout int lch, inout int ptr);
        logic v; logic [3:0] g; int idx;
        if (!rstn) begin
            lk = 1'b0; lch = 0; ptr = 0;
            return;
        end
        model_out(n, lk, lch, ptr, req, rstn, v, g, idx);
        if (!v) return;
        if (!lk) begin
            if (!rdy || !lst[idx]) begin
                lk = 1'b1; lch = idx;
            end else begin
                ptr = (idx + 1) % n;
            end
        end else if (rdy && lst[lch]) begin
            lk = 1'b0; ptr = (lch + 1) % n;
        end
    endfunction

    bit         lk4 = 0, lk1 = 0;
    int         lch4 = 0, lch1 = 0, ptr4 = 0, ptr1 = 0;
    logic       m_v;
    logic [3:0] m_g;
    int         m_i;

    always @(negedge clk) begin
        model_out(4, lk4, lch4, ptr4, req4, rst_n, m_v, m_g, m_i);
        chk("m4_valid", o_valid4, m_v);
        chk("m4_grant", o_grant4, m_g);
        chk("m4_index", o_index4, m_i[1:0]);
        chk("m4_ready", o_ready4, m_g & {4{rdy4}});
        chk("m4_onehot", ($countones(o_grant4) <= 1), 1);
        model_next(4, req4, last4, rdy4, rst_n, lk4, lch4, ptr4);

        model_out(1, lk1, lch1, ptr1, {3'b000, req1}, rst_n, m_v, m_g, m_i);
        chk("m1_valid", o_valid1, m_v);
        chk("m1_grant", o_grant1, m_g[0]);
        chk("m1_index", o_index1, 0);
        chk("m1_ready", o_ready1, m_g[0] & rdy1);
        model_next(1, {3'b000, req1}, {3'b000, last1}, rdy1, rst_n, lk1, lch1, ptr1);
    end

    task automatic cyc4(input logic [3:0] r, input logic [3:0] l, input logic rd,
                        input logic [3:0] eg, input int ei, input logic ev, input string nm);
        req4 = r; last4 = l; rdy4 = rd;
        @(negedge clk);
        chk({nm, "_grant"}, o_grant4, eg);
        chk({nm, "_index"}, o_index4, ei);
        chk({nm, "_valid"}, o_valid4, ev);
        chk({nm, "_ready"}, o_ready4, eg & {4{rd}});
        @(posedge clk); #1;
    endtask

    task automatic cyc1(input logic r, input logic l, input logic rd,
                        input logic eg, input logic ev, input string nm);
        req1 = r; last1 = l; rdy1 = rd;
        @(negedge clk);
        chk({nm, "_grant"}, o_grant1, eg);
        chk({nm, "_valid"}, o_valid1, ev);
        chk({nm, "_ready"}, o_ready1, eg & rd);
        chk({nm, "_index"}, o_index1, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        clk = 0; rst_n = 0;
        req4 = '0; last4 = '0; rdy4 = 0;
        req1 = 0; last1 = 0; rdy1 = 0;

        cyc4(4'b1010, 4'b1111, 1, 4'b0000, 0, 0, "in_reset");
        cyc4(4'b1010, 4'b1111, 1, 4'b0000, 0, 0, "in_reset2");
        rst_n = 1;
        cyc4(4'b0000, 4'b0000, 1, 4'b0000, 0, 0, "no_req");

        // Alternating ch1/ch3 single-beat packets.
        cyc4(4'b1010, 4'b1111, 1, 4'b0010, 1, 1, "rr_a");
        chk("ptr_after_ch1_a", dut4.r_pointer, 4'b0100);
        chk("model_ptr_a", ptr4, 2);
        cyc4(4'b1010, 4'b1111, 1, 4'b1000, 3, 1, "rr_b");
        cyc4(4'b1010, 4'b1111, 1, 4'b0010, 1, 1, "rr_c");
        chk("ptr_after_ch1_c", dut4.r_pointer, 4'b0100);

        // ch2 3-beat packet with ch0 and ch3 contending.
        cyc4(4'b1101, 4'b0000, 1, 4'b0100, 2, 1, "pkt_b1");
        cyc4(4'b1101, 4'b0000, 1, 4'b0100, 2, 1, "pkt_b2");
        cyc4(4'b1101, 4'b0100, 1, 4'b0100, 2, 1, "pkt_b3");
        cyc4(4'b1001, 4'b1111, 1, 4'b1000, 3, 1, "after_pkt");
        cyc4(4'b1001, 4'b1111, 1, 4'b0001, 0, 1, "wrap");

        // ch0 stalled, then ch2 joins; grant moves only after ch0's last beat.
        for (int i = 0; i < 5; i++) cyc4(4'b0001, 4'b0001, 0, 4'b0001, 0, 1, "stall");
        cyc4(4'b0101, 4'b0001, 0, 4'b0001, 0, 1, "stall_ch2");
        cyc4(4'b0101, 4'b0001, 1, 4'b0001, 0, 1, "stall_done");
        cyc4(4'b0101, 4'b0100, 1, 4'b0100, 2, 1, "to_ch2");

        // Request dropped mid-packet: grant held, valid low.
        cyc4(4'b0001, 4'b0000, 1, 4'b0001, 0, 1, "drop_b1");
        cyc4(4'b0010, 4'b0000, 1, 4'b0001, 0, 0, "drop_gap");
        cyc4(4'b0001, 4'b0001, 1, 4'b0001, 0, 1, "drop_last");

        // Reset while busy on ch3.
        cyc4(4'b1000, 4'b0000, 1, 4'b1000, 3, 1, "ch3_b1");
        cyc4(4'b1001, 4'b0000, 1, 4'b1000, 3, 1, "ch3_hold");
        rst_n = 0;
        cyc4(4'b1001, 4'b0000, 1, 4'b0000, 0, 0, "mid_reset");
        rst_n = 1;
        cyc4(4'b1001, 4'b1111, 1, 4'b0001, 0, 1, "post_reset");
        cyc4(4'b0000, 4'b0000, 0, 4'b0000, 0, 0, "quiet4");

        // Single-channel instance: 2-beat packet with ready toggling.
        cyc1(1, 0, 0, 1, 1, "one_stall");
        cyc1(1, 0, 1, 1, 1, "one_b1");
        cyc1(1, 1, 0, 1, 1, "one_b2_wait");
        cyc1(1, 1, 1, 1, 1, "one_b2");
        cyc1(0, 0, 1, 0, 0, "one_idle");
        cyc1(1, 1, 1, 1, 1, "one_next");

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/tbcm_stream_arbiter.md
Name: tbcm_stream_arbiter

Overview:
- Round-robin arbiter with valid/ready handshake and packet lock.
- Sits directly upstream of tbcm_mux and drives its select input.
- Picks one of REQUESTS upstream streams and holds that grant until the packet's last beat is accepted downstream.
- Outputs both a one-hot grant (ONE_HOT=1 mux) and a binary index (ONE_HOT=0 mux).

Parameters:
- REQUESTS, 2: number of requesting channels; legal range is 1 or more.
- INDEX_WIDTH, localparam, (REQUESTS > 1) ? $clog2(REQUESTS) : 1: width of o_grant_index.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_request  in  REQUESTS  per-channel valid.
- i_last  in  REQUESTS  per-channel last-beat flag; sampled only for the granted channel.
- o_ready  out  REQUESTS  per-channel ready, equal to o_grant & {REQUESTS{i_ready}}.
- o_grant  out  REQUESTS  one-hot grant; connects to tbcm_mux i_select when ONE_HOT=1.
- o_grant_index  out  INDEX_WIDTH  binary form of o_grant; connects to tbcm_mux i_select when ONE_HOT=0.
- o_valid  out  1  downstream valid.
- i_ready  in  1  downstream ready.

Behaviour:
- State registers:
  - state: IDLE or BUSY.
  - priority pointer: REQUESTS-bit one-hot.
  - held grant: REQUESTS-bit one-hot.
- Reset values: state=IDLE, pointer=entry 0, held grant=0.
- Outputs are combinational from state and i_request. Under reset, or whenever i_request==0 in IDLE: o_valid=0, o_grant=0, o_grant_index=0, o_ready=0.
- IDLE:
  - Winner is the first set request at or after the pointer, scanning upward and wrapping from REQUESTS-1 to 0.
  - o_grant = winner, o_valid = |i_request.
  - Latency is zero: a request is granted in the same cycle it is first presented.
- BUSY:
  - o_grant = held grant.
  - o_valid = |(i_request & held grant).
  - Other requests are ignored.
- IDLE transitions:
  - o_valid && !i_ready -> BUSY; held grant = winner. This keeps the grant stable while stalled.
  - Handshake with winner's i_last=0 -> BUSY; held grant = winner.
  - Handshake with winner's i_last=1 -> stay IDLE; pointer advances.
- BUSY transitions:
  - Handshake with held channel's i_last=1 -> IDLE; pointer advances.
  - Any other cycle -> stay BUSY.
- Pointer advance: pointer = winner rotated left by 1, so winner REQUESTS-1 wraps to entry 0.
- Grant stability: o_grant and o_grant_index must not change between o_valid rising and the handshake.
- Upstream protocol: a granted channel must hold i_request until its last beat is accepted. If it drops i_request in BUSY, o_valid=0 and the grant is still held; no error is flagged.
- Simultaneous requests: exactly one grant is issued; o_grant is never multi-hot.
- REQUESTS=1:
  - o_grant = i_request, o_grant_index = 0.
  - Pointer stays constant.
  - Lock still applies.
- Reset mid-packet: returns state to IDLE and pointer to 0 immediately. The partial packet is abandoned.

Decomposition:
- Shared package tbcm_arbiter_pkg holds the state enum typedef tbcm_arbiter_state_e (IDLE, BUSY).
- Sub-module tbcm_rr_priority: purely combinational. Inputs are request and one-hot pointer; outputs are the one-hot winner and its binary index. It is reusable by other arbiters.

Test Plan (REQUESTS=4 unless stated):
- Reset, then i_request=4'b0000 -> o_valid=0, o_grant=0, o_ready=0.
- Reset, then i_request=4'b1010, last=1, ready=1 every cycle:
  - Grants are 4'b0010, 4'b1000, 4'b0010 on consecutive cycles.
  - After each grant to ch1, the pointer is 4'b0100.
- ch2 sends a 3-beat packet (last on beat 3) while ch0 and ch3 request:
  - o_grant holds 4'b0100 for all 3 beats.
  - The next grant is ch3 (4'b1000), then ch0 on wrap-around.
- i_request=4'b0001 with i_ready=0 for 5 cycles, then ch2 also requests:
  - o_grant stays 4'b0001 and o_grant_index=0 throughout.
  - Grant moves to ch2 only after ch0's last beat is accepted.
- i_rst_n dropped for 1 cycle in BUSY on ch3 -> next cycle with i_request=4'b1001 grants ch0 (pointer back at 0).
- REQUESTS=1, 2-beat packet with ready toggling -> o_grant=1 whenever i_request=1; o_ready tracks i_ready.
